// File: rtl/serial_adder_ctrl_if.sv
// Request/ack/result bundle for the two-requester bit-serial adder.
// Ports are grouped as the requester side (master) and the adder side (slave).
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             ack0;
   logic             ack1;
   logic             busy;
   logic             done;
   logic             owner;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  ack0, ack1, busy, done, owner, sum, cout
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output ack0, ack1, busy, done, owner, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Round-robin arbitrated bit-serial adder: one addition at a time, LSB first,
// WIDTH cycles per operation, with the result registered on entry to DONE.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_adder_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-2:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             win;
   logic             ha_p, ha_g, s_bit, c_next;
   logic [WIDTH-1:0] shifted;

   // With both requesting, the one not granted last wins.
   assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

   // Two cascaded half adders on the current LSB with the registered carry.
   assign ha_p    = a_q[0] ^ b_q[0];
   assign ha_g    = a_q[0] & b_q[0];
   assign s_bit   = ha_p ^ carry_q;
   assign c_next  = ha_g | (ha_p & carry_q);
   assign shifted = {s_bit, acc_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      owner_d = owner_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d = ADD;
               a_d     = win ? bus.a1 : bus.a0;
               b_d     = win ? bus.b1 : bus.b0;
               owner_d = win;
               last_d  = win;
               ack0_d  = ~win;
               ack1_d  = win;
               carry_d = 1'b0;
               cnt_d   = '0;
            end
         end
         ADD: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = c_next;
            acc_d   = shifted[WIDTH-1:1];
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               sum_d   = shifted;
               cout_d  = c_next;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         last_q  <= 1'b1;  // pretend requester 1 went last so 0 wins first
         owner_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;
   assign bus.busy  = (state_q == ADD);
   assign bus.done  = (state_q == DONE);
   assign bus.owner = owner_q;
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: cycle model plus result scoreboard, directed
// scenarios followed by random traffic from both requesters.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(W)) sa();
   serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(sa));

   int checks = 0, failures = 0;
   int cyc = 0, n_ack = 0, n_done = 0, issued = 0;
   bit chk_en = 1'b0, hold1 = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: arbitration and timing at cycle level, sums via plain addition.
   typedef enum int {M_IDLE, M_ADD, M_DONE} mst_t;
   mst_t       m_st;
   int         m_cnt;
   logic       m_last, m_ack0, m_ack1, m_owner, m_cout;
   logic [W-1:0] m_sum;
   logic [W:0]   m_pend;
   logic         m_win;
   logic [W:0]   m_res;
   logic [W+1:0] exp_q[$];
   logic [W+1:0] e;

   assign m_win = (sa.req0 && sa.req1) ? ~m_last : sa.req1;
   assign m_res = m_win ? ({1'b0, sa.a1} + {1'b0, sa.b1}) : ({1'b0, sa.a0} + {1'b0, sa.b0});

   always @(posedge clk) begin
      if (rst) begin
         m_st <= M_IDLE; m_cnt <= 0; m_last <= 1'b1; m_ack0 <= 1'b0; m_ack1 <= 1'b0;
         m_owner <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
         exp_q.delete();
      end else begin
         m_ack0 <= 1'b0;
         m_ack1 <= 1'b0;
         case (m_st)
            M_IDLE: if (sa.req0 || sa.req1) begin
               m_pend  <= m_res;
               m_owner <= m_win;
               m_last  <= m_win;
               m_ack0  <= ~m_win;
               m_ack1  <= m_win;
               m_cnt   <= 0;
               m_st    <= M_ADD;
               exp_q.push_back({m_win, m_res});
            end
            M_ADD: if (m_cnt == W - 1) begin
               m_st <= M_DONE;
               {m_cout, m_sum} <= m_pend;
            end else begin
               m_cnt <= m_cnt + 1;
            end
            default: m_st <= M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack0", sa.ack0, m_ack0);
         chk("ack1", sa.ack1, m_ack1);
         chk("busy", sa.busy, m_st == M_ADD);
         chk("done", sa.done, m_st == M_DONE);
         chk("owner", sa.owner, m_owner);
         chk("sum_hold", sa.sum, m_sum);
         chk("cout_hold", sa.cout, m_cout);
         chk("no_double_ack", sa.ack0 & sa.ack1, 1'b0);
         if (sa.ack0 || sa.ack1) n_ack++;
         if (sa.done) n_done++;
         if (m_st == M_DONE) begin
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("sb_result", {sa.owner, sa.cout, sa.sum}, e);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (sa.ack0) sa.req0 = 1'b0;
      if (sa.ack1 && !hold1) sa.req1 = 1'b0;
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin tick(); n++; end while (!(sa.ack0 || sa.ack1) && n < 40);
      chk("ack_seen", sa.ack0 | sa.ack1, 1'b1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin tick(); n++; end while (!sa.done && n < 40);
      chk("done_seen", sa.done, 1'b1);
   endtask

   task automatic run_op(input string tag, input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
      int n;
      if (who) begin sa.a1 = a; sa.b1 = b; sa.req1 = 1'b1; end
      else     begin sa.a0 = a; sa.b0 = b; sa.req0 = 1'b1; end
      wait_ack(n);
      chk({tag, "_ack_lat"}, n, 1);
      chk({tag, "_ack_who"}, sa.ack1, who);
      wait_done(n);
      chk({tag, "_done_lat"}, n, W);
      chk({tag, "_sum"}, sa.sum, exp_sum);
      chk({tag, "_cout"}, sa.cout, exp_cout);
      chk({tag, "_owner"}, sa.owner, who);
      tick();
   endtask

   initial begin
      int n, c0;
      rst = 1'b1;
      sa.req0 = 1'b0; sa.a0 = '0; sa.b0 = '0;
      sa.req1 = 1'b0; sa.a1 = '0; sa.b1 = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ack0", sa.ack0, 1'b0);
      chk("rst_busy", sa.busy, 1'b0);
      chk("rst_done", sa.done, 1'b0);
      chk("rst_sum", sa.sum, 8'h00);

      run_op("zero", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      run_op("ff_p1", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
      run_op("80_80", 1'b1, 8'h80, 8'h80, 8'h00, 1'b1);

      // Both requesting straight after reset: requester 0 first.
      rst = 1'b1; tick(); rst = 1'b0;
      sa.a0 = 8'h0F; sa.b0 = 8'h01; sa.a1 = 8'hAA; sa.b1 = 8'h55;
      sa.req0 = 1'b1; sa.req1 = 1'b1;
      wait_ack(n);
      chk("both_first_ack0", sa.ack0, 1'b1);
      c0 = cyc;
      wait_done(n);
      chk("both_sum0", sa.sum, 8'h10);
      wait_ack(n);
      chk("both_second_ack1", sa.ack1, 1'b1);
      chk("both_spacing", cyc - c0, 10);
      wait_done(n);
      chk("both_sum1", sa.sum, 8'hFF);
      chk("both_cout1", sa.cout, 1'b0);
      chk("both_owner1", sa.owner, 1'b1);
      tick();

      // req1 held high, req0 arrives mid-ADD: grants 1,0,1.
      rst = 1'b1; tick(); rst = 1'b0;
      hold1 = 1'b1;
      sa.a1 = 8'h12; sa.b1 = 8'h34; sa.req1 = 1'b1;
      wait_ack(n);
      chk("rr_g1", sa.ack1, 1'b1);
      c0 = cyc;
      repeat (3) tick();
      sa.a0 = 8'h01; sa.b0 = 8'h02; sa.req0 = 1'b1;
      wait_ack(n);
      chk("rr_g2", sa.ack0, 1'b1);
      chk("rr_sp2", cyc - c0, 10);
      c0 = cyc;
      wait_ack(n);
      chk("rr_g3", sa.ack1, 1'b1);
      chk("rr_sp3", cyc - c0, 10);
      hold1 = 1'b0;
      sa.req1 = 1'b0;
      wait_done(n);
      tick();

      // Reset in ADD cycle 4 discards the operation.
      sa.a0 = 8'h33; sa.b0 = 8'h44; sa.req0 = 1'b1;
      wait_ack(n);
      repeat (3) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_ack0", sa.ack0, 1'b0);
      chk("mid_rst_ack1", sa.ack1, 1'b0);
      chk("mid_rst_busy", sa.busy, 1'b0);
      chk("mid_rst_done", sa.done, 1'b0);
      chk("mid_rst_owner", sa.owner, 1'b0);
      chk("mid_rst_sum", sa.sum, 8'h00);
      chk("mid_rst_cout", sa.cout, 1'b0);
      run_op("after_rst", 1'b0, 8'h33, 8'h44, 8'h77, 1'b0);

      // Random traffic on both requesters.
      n_ack = 0; n_done = 0; issued = 0;
      for (int c = 0; c < 30000 && (issued < 1000 || sa.req0 || sa.req1); c++) begin
         tick();
         if (!sa.req0 && issued < 1000 && $urandom_range(0, 1) == 1) begin
            sa.a0 = W'($urandom); sa.b0 = W'($urandom); sa.req0 = 1'b1; issued++;
         end
         if (!sa.req1 && issued < 1000 && $urandom_range(0, 1) == 1) begin
            sa.a1 = W'($urandom); sa.b1 = W'($urandom); sa.req1 = 1'b1; issued++;
         end
      end
      repeat (W + 4) tick();
      chk("rand_issued", issued, 1000);
      chk("rand_acks", n_ack, issued);
      chk("rand_dones", n_done, issued);
      chk("rand_sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2..32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port req0  input  1  requester 0 asks for one addition; held high until ack0.
REQ-006 Port a0, b0  input  WIDTH  requester 0 operands; stable while req0 is high.
REQ-007 Port req1  input  1  requester 1 request; same rules as req0.
REQ-008 Port a1, b1  input  WIDTH  requester 1 operands.
REQ-009 Port ack0, ack1  output  1  one-cycle grant/accept pulse per requester.
REQ-010 Port busy  output  1  high while an addition is in progress (ADD state).
REQ-011 Port done  output  1  one-cycle pulse; sum and cout hold a new result.
REQ-012 Port owner  output  1  index of the requester whose result is in progress or was last delivered.
REQ-013 Port sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
REQ-014 Port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-015 The block SHALL implement states IDLE, ADD and DONE; reset enters IDLE.
REQ-016 In IDLE, a rising edge with req0 or req1 high SHALL:
- latch the winner's operands;
- set owner to the winner;
- clear the carry and bit counter;
- enter ADD.
REQ-017 In the cycle after the acceptance edge, the winner's ack SHALL be high for exactly one cycle and busy SHALL be high.
REQ-018 Arbitration SHALL be round-robin:
- With one requester high, that requester wins.
- With both high, the requester not granted last wins.
- After reset, requester 0 has priority.
REQ-019 Requests SHALL be sampled only in IDLE; req changes during ADD/DONE SHALL have no effect.
REQ-020 ADD SHALL process one bit per cycle, LSB first, through two cascaded half adders (s = a^b^c, c = a&b | c&(a^b)), with the carry registered between bits.
REQ-021 ADD SHALL last exactly WIDTH cycles; the counter runs 0..WIDTH-1, and at count WIDTH-1 the state moves to DONE.
REQ-022 sum and cout SHALL update only on the edge entering DONE; otherwise they hold the last result, including through later ADD phases.
REQ-023 done SHALL be high for exactly the one DONE cycle, rising WIDTH cycles after ack rises; busy SHALL be low in DONE.
REQ-024 DONE SHALL return to IDLE unconditionally, so the minimum ack-to-ack spacing is WIDTH+2 cycles.
REQ-025 Overflow SHALL be reported only via cout; sum wraps modulo 2^WIDTH.
REQ-026 ack0 and ack1 SHALL never be high in the same cycle, and at most one operation SHALL be in flight.

Reset
REQ-027 While rst is high at an edge, the block SHALL:
- enter IDLE;
- drive ack0, ack1, busy, done, owner, sum and cout to 0;
- clear the carry and counter;
- reset the round-robin pointer to favour requester 0.
REQ-028 Reset during ADD or DONE SHALL discard the operation with no done pulse; a still-high request SHALL be arbitrated normally on the first non-reset IDLE edge.

Verification (WIDTH=8)
REQ-029 After reset, req0 with 0x00+0x00 -> ack0 in cycle 1, busy cycles 1-8, done in cycle 9, sum=0x00, cout=0, owner=0.
REQ-030 req0 with 0xFF+0x01 -> done, sum=0x00, cout=1; req1 with 0x80+0x80 -> sum=0x00, cout=1, owner=1.
REQ-031 Both requests high after reset: req0 0x0F+0x01 and req1 0xAA+0x55 -> first ack0, done with sum=0x10; then ack1 10 cycles later, done with sum=0xFF, cout=0.
REQ-032 req1 held permanently high with req0 raised during an ADD -> grants alternate 1,0,1 at 10-cycle ack spacing, and no double ack occurs.
REQ-033 rst pulsed in ADD cycle 4 -> no done, all outputs 0 the next cycle; the re-presented request completes with the correct sum.
REQ-034 1000 random operand pairs with random requests -> every done matches a+b (sum, cout) for the correct owner, and every ack has exactly one done.
